// File: rtl/alarm_clock_ctrl.sv
// Alarm-clock mode/sequencing controller: 1 Hz prescaler, RUN/SET FSM,
// per-field counter strobes, set-mode timeout, blink and buzzer.
module alarm_clock_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 30,
  parameter int RING_S    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       alarm_en,
  input  logic       sec_wrap,
  input  logic       min_wrap,
  input  logic       time_match,
  output logic       tick_1hz,
  output logic       sec_en,
  output logic       tmin_en,
  output logic       thr_en,
  output logic       amin_en,
  output logic       ahr_en,
  output logic       cnt_up,
  output logic [2:0] mode,
  output logic       blink,
  output logic       buzzer
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_TH = 3'd1,
    SET_TM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_t;

  localparam int PW = $clog2(CLK_HZ);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int RW = $clog2(RING_S + 1);

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_to;
  logic [RW-1:0] r_ring;
  logic          r_mode_q, r_up_q, r_dn_q;
  logic          r_tick, r_blink, r_buzzer, r_blk;
  logic          r_sec, r_tmin, r_thr, r_amin, r_ahr, r_up;

  logic w_mode_e, w_up_e, w_dn_e, w_any_e;
  logic w_pre_end, w_live, w_adj;

  assign w_mode_e  = btn_mode & ~r_mode_q;
  assign w_up_e    = btn_up & ~r_up_q;
  assign w_dn_e    = btn_down & ~r_dn_q;
  assign w_any_e   = w_mode_e | w_up_e | w_dn_e;
  assign w_adj     = w_up_e ^ w_dn_e;
  assign w_pre_end = (r_pre == PW'(CLK_HZ - 1));
  // Time keeps running in RUN and while editing the alarm fields
  assign w_live    = (r_state == RUN) || (r_state == SET_AH)
                  || (r_state == SET_AM);

  always_comb begin
    w_next = RUN;
    unique case (r_state)
      RUN:     w_next = SET_TH;
      SET_TH:  w_next = SET_TM;
      SET_TM:  w_next = SET_AH;
      SET_AH:  w_next = SET_AM;
      SET_AM:  w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_pre    <= '0;
      r_to     <= '0;
      r_ring   <= '0;
      r_mode_q <= 1'b1;
      r_up_q   <= 1'b1;
      r_dn_q   <= 1'b1;
      r_tick   <= 1'b0;
      r_blink  <= 1'b0;
      r_buzzer <= 1'b0;
      r_blk    <= 1'b0;
      r_sec    <= 1'b0;
      r_tmin   <= 1'b0;
      r_thr    <= 1'b0;
      r_amin   <= 1'b0;
      r_ahr    <= 1'b0;
      r_up     <= 1'b1;
    end else begin
      r_mode_q <= btn_mode;
      r_up_q   <= btn_up;
      r_dn_q   <= btn_down;
      r_pre    <= w_pre_end ? '0 : r_pre + PW'(1);
      r_tick   <= w_pre_end;

      r_sec  <= 1'b0;
      r_tmin <= 1'b0;
      r_thr  <= 1'b0;
      r_amin <= 1'b0;
      r_ahr  <= 1'b0;
      r_up   <= 1'b1;

      if (w_live && r_tick) begin
        r_sec  <= 1'b1;
        r_tmin <= sec_wrap;
        r_thr  <= sec_wrap & min_wrap;
      end

      // Re-arm only once the match has gone away
      if (!time_match)
        r_blk <= 1'b0;

      if (r_buzzer) begin
        if (w_any_e || !alarm_en
            || (r_tick && r_ring == RW'(RING_S - 1))) begin
          r_buzzer <= 1'b0;
          r_blk    <= 1'b1;
        end else if (r_tick) begin
          r_ring <= r_ring + RW'(1);
        end
      end else if (w_live && r_tick && alarm_en
                   && time_match && !r_blk) begin
        r_buzzer <= 1'b1;
        r_ring   <= '0;
      end

      if (r_buzzer && w_any_e) begin
        r_to <= '0;
      end else if (w_mode_e) begin
        r_state <= w_next;
        r_to    <= '0;
        if (w_next == RUN)
          r_blink <= 1'b0;
      end else if (r_state != RUN) begin
        if (w_adj) begin
          r_up <= w_up_e;
          unique case (r_state)
            SET_TH:  r_thr  <= 1'b1;
            SET_TM:  r_tmin <= 1'b1;
            SET_AH:  r_ahr  <= 1'b1;
            SET_AM:  r_amin <= 1'b1;
            default: ;
          endcase
        end
        if (w_any_e) begin
          r_to <= '0;
        end else if (r_tick) begin
          if (r_to == TW'(TIMEOUT_S - 1)) begin
            r_state <= RUN;
            r_to    <= '0;
            r_blink <= 1'b0;
          end else begin
            r_to    <= r_to + TW'(1);
            r_blink <= ~r_blink;
          end
        end
      end
    end
  end

  assign tick_1hz = r_tick;
  assign sec_en   = r_sec;
  assign tmin_en  = r_tmin;
  assign thr_en   = r_thr;
  assign amin_en  = r_amin;
  assign ahr_en   = r_ahr;
  assign cnt_up   = r_up;
  assign mode     = r_state;
  assign blink    = r_blink;
  assign buzzer   = r_buzzer;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl with a 4-cycle second,
// 3 s set timeout and 2 s ring limit.
module tb_alarm_clock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic alarm_en = 1'b0, sec_wrap = 1'b0, min_wrap = 1'b0;
  logic time_match = 1'b0;
  logic tick_1hz, sec_en, tmin_en, thr_en, amin_en, ahr_en;
  logic cnt_up, blink, buzzer;
  logic [2:0] mode;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alarm_clock_ctrl #(
    .CLK_HZ(4), .TIMEOUT_S(3), .RING_S(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .alarm_en(alarm_en), .sec_wrap(sec_wrap), .min_wrap(min_wrap),
    .time_match(time_match),
    .tick_1hz(tick_1hz), .sec_en(sec_en), .tmin_en(tmin_en),
    .thr_en(thr_en), .amin_en(amin_en), .ahr_en(ahr_en),
    .cnt_up(cnt_up), .mode(mode), .blink(blink), .buzzer(buzzer)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic m, input logic u,
                       input logic d);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    step();
  endtask

  task automatic rel();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (!tick_1hz && n < 20) begin
      step();
      n++;
    end
    chk(tag, tick_1hz, 1);
  endtask

  initial begin
    int n;
    int ticks;
    step(); step(); step();
    chk("rst_sec", sec_en, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_up", cnt_up, 1);
    chk("rst_mode", mode, 0);
    chk("rst_buz", buzzer, 0);
    rst = 1'b0;

    n = 0;
    while (!tick_1hz && n < 10) begin
      step();
      n++;
    end
    chk("first_tick", n, 4);
    step();
    chk("sec_after", sec_en, 1);
    chk("tick_low", tick_1hz, 0);
    chk("tmin_nowrap", tmin_en, 0);
    step(); step(); step();
    chk("tick_per4", tick_1hz, 1);

    sec_wrap = 1'b1;
    min_wrap = 1'b1;
    step();
    chk("wr_sec", sec_en, 1);
    chk("wr_tmin", tmin_en, 1);
    chk("wr_thr", thr_en, 1);
    chk("wr_up", cnt_up, 1);
    sec_wrap = 1'b0;
    min_wrap = 1'b0;
    step();
    chk("wr_pulse", sec_en, 0);

    press(1, 1, 0);
    chk("mu_mode", mode, 1);
    chk("mu_thr", thr_en, 0);
    rel(); step();
    press(0, 1, 1);
    chk("ud_thr", thr_en, 0);
    chk("ud_up", cnt_up, 1);
    rel(); step();
    press(0, 1, 0);
    chk("adj_thr", thr_en, 1);
    chk("adj_up", cnt_up, 1);
    chk("adj_sec", sec_en, 0);
    rel();
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      if (tick_1hz) begin
        ticks++;
        if (ticks == 2) chk("blink_on", blink, 1);
        if (ticks == 3) break;
      end
      step();
    end
    chk("to_hold", mode, 1);
    step();
    chk("to_run", mode, 0);
    chk("to_blink", blink, 0);

    step();
    press(1, 0, 0); chk("m1", mode, 1); rel(); step();
    press(1, 0, 0); chk("m2", mode, 2); rel(); step();
    press(0, 0, 1);
    chk("dn_tmin", tmin_en, 1);
    chk("dn_up", cnt_up, 0);
    chk("dn_sec", sec_en, 0);
    rel(); step();
    chk("dn_tmin0", tmin_en, 0);
    chk("dn_up1", cnt_up, 1);
    press(1, 0, 0); chk("m3", mode, 3); rel(); step();
    press(1, 0, 0); chk("m4", mode, 4); rel(); step();
    press(1, 0, 0); chk("m0", mode, 0); rel(); step();

    alarm_en   = 1'b1;
    time_match = 1'b1;
    wait_tick("al_tick");
    step();
    chk("al_on", buzzer, 1);
    press(0, 1, 0);
    chk("dis_buz", buzzer, 0);
    chk("dis_thr", thr_en, 0);
    chk("dis_amin", amin_en, 0);
    chk("dis_mode", mode, 0);
    rel(); step();
    wait_tick("sup_tick");
    step();
    chk("sup_buz", buzzer, 0);
    time_match = 1'b0;
    step();
    time_match = 1'b1;
    wait_tick("rearm_tick");
    step();
    chk("rearm_buz", buzzer, 1);
    wait_tick("ring_t1");
    step();
    chk("ring_hold", buzzer, 1);
    wait_tick("ring_t2");
    chk("ring_pre", buzzer, 1);
    step();
    chk("ring_end", buzzer, 0);

    time_match = 1'b0;
    press(1, 0, 0); rel(); step();
    press(1, 0, 0); rel(); step();
    press(1, 0, 0); rel(); step();
    chk("r6_mode", mode, 3);
    time_match = 1'b1;
    wait_tick("r6_tick");
    step();
    chk("r6_buz", buzzer, 1);
    rst = 1'b1;
    step();
    chk("r6_buz0", buzzer, 0);
    chk("r6_mode0", mode, 0);
    chk("r6_sec", sec_en, 0);
    chk("r6_ahr", ahr_en, 0);
    chk("r6_up", cnt_up, 1);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
